// File: rtl/writeback_unit.sv
// Register-file write port: merges ALU results with in-order load responses, extends load data.
// Define WB_FWD_EN to add the fwd_valid/fwd_rd/fwd_data bypass outputs.
module writeback_unit #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            alu_valid,
  output logic                            alu_ready,
  input  logic [4:0]                      alu_rd,
  input  logic [XLEN-1:0]                 alu_data,
  input  logic                            ld_issue,
  output logic                            ld_ready,
  input  logic [4:0]                      ld_rd,
  input  logic [2:0]                      ld_funct3,
  input  logic [1:0]                      ld_off,
  input  logic                            mem_rvalid,
  input  logic [XLEN-1:0]                 mem_rdata,
  output logic [4:0]                      rd,
  output logic [XLEN-1:0]                 xd,
  output logic                            rd_en,
  output logic [31:0]                     pending,
  output logic [$clog2(LQ_DEPTH+1)-1:0]   lq_count,
  output logic                            mem_err
`ifdef WB_FWD_EN
  ,
  output logic                            fwd_valid,
  output logic [4:0]                      fwd_rd,
  output logic [XLEN-1:0]                 fwd_data
`endif
);

  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = $clog2(LQ_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(LQ_DEPTH);

  logic [4:0]      q_rd  [LQ_DEPTH];
  logic [2:0]      q_f3  [LQ_DEPTH];
  logic [1:0]      q_off [LQ_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;

  logic            push, pop, alu_acc, wb_take;
  logic [4:0]      head_rd, wb_rd;
  logic [2:0]      head_f3;
  logic [1:0]      head_off;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data, wb_data;
  logic [PW-1:0]   slot_age;

  // Push is gated on occupancy alone, so a same-cycle pop never frees a slot early.
  assign ld_ready  = (lq_count < DEPTH_C);
  assign push      = ld_issue && ld_ready;
  assign pop       = mem_rvalid && (lq_count != '0);
  assign alu_ready = !pop;
  assign alu_acc   = alu_valid && alu_ready;

  assign head_rd  = q_rd[rd_ptr];
  assign head_f3  = q_f3[rd_ptr];
  assign head_off = q_off[rd_ptr];

  always_comb begin
    ld_byte = 8'h00;
    case (head_off)
      2'd0: ld_byte = mem_rdata[7:0];
      2'd1: ld_byte = mem_rdata[15:8];
      2'd2: ld_byte = mem_rdata[23:16];
      2'd3: ld_byte = mem_rdata[31:24];
      default: ld_byte = 8'h00;
    endcase
    ld_half = head_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (head_f3)
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  assign wb_take = pop || alu_acc;
  assign wb_rd   = pop ? head_rd : alu_rd;
  assign wb_data = pop ? ld_data : alu_data;

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    pending  = '0;
    slot_age = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      slot_age = PW'(i) - rd_ptr;
      if ((CW'(slot_age) < lq_count) && (q_rd[i] != 5'd0))
        pending[q_rd[i]] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]  <= ld_rd;
      q_f3[wr_ptr]  <= ld_funct3;
      q_off[wr_ptr] <= ld_off;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      lq_count <= '0;
      mem_err  <= 1'b0;
      rd       <= '0;
      xd       <= '0;
      rd_en    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      lq_count <= lq_count + CW'(push) - CW'(pop);
      if (mem_rvalid && (lq_count == '0)) mem_err <= 1'b1;
      rd_en <= wb_take && (wb_rd != 5'd0);
      if (wb_take) begin
        rd <= wb_rd;
        xd <= wb_data;
      end
    end
  end

`ifdef WB_FWD_EN
  assign fwd_valid = wb_take && (wb_rd != 5'd0);
  assign fwd_rd    = wb_rd;
  assign fwd_data  = wb_data;
`endif

endmodule
